// File: rtl/pmcc_code_mem.sv
// PMC program store: two interleaved 32-bit word banks with an unaligned, wrapping
// 4-byte fetch port and a host load/readback port that is served only while fetch is idle.
module pmcc_code_mem #(
    parameter int unsigned WORDS = 64,
    parameter int unsigned PC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [PC_W-1:0]   pc_if,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              host_req,
    output logic              host_gnt,
    input  logic              host_we,
    input  logic [PC_W-3:0]   host_addr,
    input  logic [3:0]        host_be,
    input  logic [31:0]       host_wdata,
    output logic [31:0]       host_rdata,
    output logic              host_rvalid
);

    localparam int unsigned WA_W = PC_W - 2;
    localparam int unsigned RA_W = PC_W - 3;
    localparam int unsigned ROWS = WORDS / 2;

    logic [31:0] bank_even [ROWS];
    logic [31:0] bank_odd  [ROWS];

    // Fetch addressing: consecutive words always land in opposite banks
    logic [WA_W-1:0] w0;
    logic [WA_W-1:0] w1;
    logic [1:0]      off;
    logic [RA_W-1:0] even_row;
    logic [RA_W-1:0] odd_row;
    logic [31:0]     even_word;
    logic [31:0]     odd_word;
    logic [31:0]     lo_word;
    logic [31:0]     hi_word;
    logic [31:0]     instr_d;

    assign w0  = pc_if[PC_W-1:2];
    assign w1  = w0 + WA_W'(1);
    assign off = pc_if[1:0];

    always_comb begin
        even_row = w0[WA_W-1:1];
        odd_row  = w0[WA_W-1:1];
        if (w0[0]) begin
            even_row = w1[WA_W-1:1];
        end else begin
            odd_row  = w1[WA_W-1:1];
        end
    end

    assign even_word = bank_even[even_row];
    assign odd_word  = bank_odd[odd_row];
    assign lo_word   = w0[0] ? odd_word  : even_word;
    assign hi_word   = w0[0] ? even_word : odd_word;

    // Byte pc goes to instr[7:0]; upper bytes spill over into the following word
    always_comb begin
        instr_d = lo_word;
        case (off)
            2'd0: instr_d = lo_word;
            2'd1: instr_d = {hi_word[7:0],  lo_word[31:8]};
            2'd2: instr_d = {hi_word[15:0], lo_word[31:16]};
            2'd3: instr_d = {hi_word[23:0], lo_word[31:24]};
            default: instr_d = lo_word;
        endcase
    end

    // Host port: fetch always wins, so a bank never sees two accesses in one cycle
    logic [RA_W-1:0] host_row;
    logic            host_odd;
    logic [31:0]     host_word;
    logic            host_wr;
    logic            host_rd;

    assign host_gnt  = host_req & ~fetch_en;
    assign host_row  = host_addr[WA_W-1:1];
    assign host_odd  = host_addr[0];
    assign host_word = host_odd ? bank_odd[host_row] : bank_even[host_row];
    assign host_wr   = host_gnt & host_we;
    assign host_rd   = host_gnt & ~host_we;

    // Storage has no reset; contents survive rst
    always_ff @(posedge clk) begin
        if (host_wr && !host_odd) begin
            for (int i = 0; i < 4; i++) begin
                if (host_be[i]) begin
                    bank_even[host_row][8*i +: 8] <= host_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (host_wr && host_odd) begin
            for (int i = 0; i < 4; i++) begin
                if (host_be[i]) begin
                    bank_odd[host_row][8*i +: 8] <= host_wdata[8*i +: 8];
                end
            end
        end
    end

    // Output registers; instr and host_rdata hold their last value when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            host_rdata  <= 32'h0;
            host_rvalid <= 1'b0;
        end else begin
            instr_valid <= fetch_en;
            if (fetch_en) begin
                instr <= instr_d;
            end
            host_rvalid <= host_rd;
            if (host_rd) begin
                host_rdata <= host_word;
            end
        end
    end

endmodule
